// File: rtl/rv_encoder.sv
// rv_encoder: pipelined RV64IM instruction encoder with a valid/ready output FIFO.
//   clk, resetn                : clock, asynchronous active-low reset
//   flush                      : synchronous clear of stage register and FIFO
//   in_valid/in_ready          : request handshake (op, alufunc, regs, imm, memf3)
//   out_valid/out_ready        : FIFO head handshake (out_instr, out_err)
//   err_count                  : saturating count of errored words pushed

package rv_encoder_pkg;

    typedef enum logic [3:0] {
        OP_ALUI, OP_ALU, OP_ALUIW, OP_ALUW, OP_LUI, OP_AUIPC,
        OP_JAL, OP_JALR, OP_BZ, OP_BNZ, OP_LD, OP_SD
    } decode_op_t;

    typedef enum logic [4:0] {
        F_ADD, F_SUB, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_SRA, F_OR, F_AND,
        F_MULT, F_DIV, F_DIVU, F_REM, F_REMU, F_EQL, F_CPYB, F_NOTALU
    } alufunc_t;

    typedef struct packed {
        decode_op_t  op;
        alufunc_t    func;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  memf3;
    } enc_req_t;

endpackage

module rv_encoder
    import rv_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  decode_op_t  in_op,
    input  alufunc_t    in_alufunc,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_memf3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] err_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             s1_valid_q, s1_valid_d;
    enc_req_t         s1_req_q, s1_req_d;
    logic [32:0]      mem_q [DEPTH];
    logic [32:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic        enc_err_c;
    logic [31:0] enc_instr_c;
    logic        pop_c, push_c, accept_c, room_c;

    // Combinational encode of the S1 request, with legality checks
    always_comb begin
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        base, mext, is_shift, is_add, legal;
        logic        imm_i_ok, imm_b_ok, imm_j_ok, sh64_ok, sh32_ok;
        logic [1:0]  br_f;
        logic        br_ok;
        logic [31:0] imm;
        logic [31:0] instr;

        f3 = 3'b000; f7 = 7'b0000000; base = 1'b0; mext = 1'b0;
        br_f = 2'b00; br_ok = 1'b0; legal = 1'b0; instr = '0;
        imm = s1_req_q.imm;

        unique case (s1_req_q.func)
            F_ADD:  begin f3 = 3'b000; base = 1'b1; end
            F_SUB:  begin f3 = 3'b000; f7 = 7'b0100000; base = 1'b1; end
            F_SLL:  begin f3 = 3'b001; base = 1'b1; end
            F_SLT:  begin f3 = 3'b010; base = 1'b1; end
            F_SLTU: begin f3 = 3'b011; base = 1'b1; end
            F_XOR:  begin f3 = 3'b100; base = 1'b1; end
            F_SRL:  begin f3 = 3'b101; base = 1'b1; end
            F_SRA:  begin f3 = 3'b101; f7 = 7'b0100000; base = 1'b1; end
            F_OR:   begin f3 = 3'b110; base = 1'b1; end
            F_AND:  begin f3 = 3'b111; base = 1'b1; end
            F_MULT: begin f3 = 3'b000; f7 = 7'b0000001; mext = 1'b1; end
            F_DIV:  begin f3 = 3'b100; f7 = 7'b0000001; mext = 1'b1; end
            F_DIVU: begin f3 = 3'b101; f7 = 7'b0000001; mext = 1'b1; end
            F_REM:  begin f3 = 3'b110; f7 = 7'b0000001; mext = 1'b1; end
            F_REMU: begin f3 = 3'b111; f7 = 7'b0000001; mext = 1'b1; end
            default: ;
        endcase

        // Branch compare kind lives in funct3[2:1]; funct3[0] selects the negated form
        unique case (s1_req_q.func)
            F_EQL:   begin br_f = 2'b00; br_ok = 1'b1; end
            F_SLT:   begin br_f = 2'b10; br_ok = 1'b1; end
            F_SLTU:  begin br_f = 2'b11; br_ok = 1'b1; end
            default: ;
        endcase

        is_shift = (s1_req_q.func == F_SLL) || (s1_req_q.func == F_SRL) ||
                   (s1_req_q.func == F_SRA);
        is_add   = (s1_req_q.func == F_ADD);

        // Signed ranges expressed as "upper bits are a pure sign extension"
        imm_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
        imm_b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
        imm_j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
        sh64_ok  = ~(|imm[31:6]);
        sh32_ok  = ~(|imm[31:5]);

        unique case (s1_req_q.op)
            OP_ALU: begin
                legal = base | mext;
                instr = {f7, s1_req_q.rs2, s1_req_q.rs1, f3, s1_req_q.rd, 7'b0110011};
            end
            OP_ALUW: begin
                legal = mext | (base & (is_add | is_shift | (s1_req_q.func == F_SUB)));
                instr = {f7, s1_req_q.rs2, s1_req_q.rs1, f3, s1_req_q.rd, 7'b0111011};
            end
            OP_ALUI: begin
                if (is_shift) begin
                    legal = sh64_ok;
                    instr = {f7[6:1], imm[5:0], s1_req_q.rs1, f3, s1_req_q.rd, 7'b0010011};
                end else begin
                    legal = base & (s1_req_q.func != F_SUB) & imm_i_ok;
                    instr = {imm[11:0], s1_req_q.rs1, f3, s1_req_q.rd, 7'b0010011};
                end
            end
            OP_ALUIW: begin
                if (is_shift) begin
                    legal = sh32_ok;
                    instr = {f7, imm[4:0], s1_req_q.rs1, f3, s1_req_q.rd, 7'b0011011};
                end else begin
                    legal = is_add & imm_i_ok;
                    instr = {imm[11:0], s1_req_q.rs1, f3, s1_req_q.rd, 7'b0011011};
                end
            end
            OP_LUI: begin
                legal = (s1_req_q.func == F_CPYB) & ~(|imm[11:0]);
                instr = {imm[31:12], s1_req_q.rd, 7'b0110111};
            end
            OP_AUIPC: begin
                legal = is_add & ~(|imm[11:0]);
                instr = {imm[31:12], s1_req_q.rd, 7'b0010111};
            end
            OP_JAL: begin
                legal = is_add & imm_j_ok;
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], s1_req_q.rd, 7'b1101111};
            end
            OP_JALR: begin
                legal = is_add & imm_i_ok;
                instr = {imm[11:0], s1_req_q.rs1, 3'b000, s1_req_q.rd, 7'b1100111};
            end
            OP_BZ, OP_BNZ: begin
                legal = br_ok & imm_b_ok;
                instr = {imm[12], imm[10:5], s1_req_q.rs2, s1_req_q.rs1,
                         br_f, (s1_req_q.op == OP_BNZ), imm[4:1], imm[11], 7'b1100011};
            end
            OP_LD: begin
                legal = is_add & imm_i_ok;
                instr = {imm[11:0], s1_req_q.rs1, s1_req_q.memf3, s1_req_q.rd, 7'b0000011};
            end
            OP_SD: begin
                legal = is_add & imm_i_ok & ~s1_req_q.memf3[2];
                instr = {imm[11:5], s1_req_q.rs2, s1_req_q.rs1, s1_req_q.memf3,
                         imm[4:0], 7'b0100011};
            end
            default: legal = 1'b0;
        endcase

        enc_err_c   = ~legal;
        enc_instr_c = legal ? instr : NOP;
    end

    // Handshake terms; a pop frees a slot for a same-cycle push even when full
    assign out_valid = (cnt_q != '0);
    assign pop_c     = out_valid && out_ready;
    assign room_c    = (cnt_q < CNT_W'(DEPTH)) || pop_c;
    assign push_c    = s1_valid_q && room_c;
    assign in_ready  = !s1_valid_q || room_c;
    assign accept_c  = in_valid && in_ready;

    assign out_instr = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign out_err   = out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
    assign err_count = err_cnt_q;

    // Next-state for stage register, FIFO and error counter; flush takes priority
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_req_d   = s1_req_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_cnt_d  = err_cnt_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = {enc_err_c, enc_instr_c};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                if (enc_err_c && (err_cnt_q != 16'hFFFF)) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);

            if (accept_c) begin
                s1_valid_d = 1'b1;
                s1_req_d   = '{op: in_op, func: in_alufunc, rd: in_rd, rs1: in_rs1,
                               rs2: in_rs2, imm: in_imm, memf3: in_memf3};
            end else if (push_c) begin
                s1_valid_d = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '{op: OP_ALUI, func: F_ADD, default: '0};
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_rv_encoder.sv
// Directed-vector testbench for rv_encoder.
module tb_rv_encoder;
    import rv_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    decode_op_t  in_op;
    alufunc_t    in_alufunc;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr;
    logic [2:0]  in_memf3;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        decode_op_t  op;
        alufunc_t    f;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  m3;
        logic [31:0] exp_i;
        logic        exp_e;
    } vec_t;

    rv_encoder #(.DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_alufunc(in_alufunc),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_memf3(in_memf3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input decode_op_t op, input alufunc_t f, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                                input logic [2:0] m3, input logic [31:0] exp_i, input logic exp_e);
        vec_t v;
        v.op = op; v.f = f; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.m3 = m3; v.exp_i = exp_i; v.exp_e = exp_e;
        return v;
    endfunction

    task automatic drive_req(input vec_t v);
        in_op = v.op; in_alufunc = v.f; in_rd = v.rd; in_rs1 = v.rs1;
        in_rs2 = v.rs2; in_imm = v.imm; in_memf3 = v.m3;
    endtask

    // One request through an idle pipe; lat = cycles from accept edge to out_valid, -1 on timeout
    task automatic send_one(input vec_t v, output logic [31:0] instr, output logic err, output int lat);
        drive_req(v);
        in_valid = 1'b1; out_ready = 1'b0; lat = -1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = c; break; end
        end
        instr = out_instr; err = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 00000000", out_instr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b exp 0", out_err); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    endtask

    task automatic test_encode;
        vec_t v[11];
        logic [31:0] instr; logic err; int lat;
        v[0]  = mk(OP_ALUI,  F_ADD,  5'd1,  5'd0,  5'd0,  32'd5,         3'd0, 32'h00500093, 1'b0);
        v[1]  = mk(OP_ALU,   F_SUB,  5'd3,  5'd1,  5'd2,  32'd0,         3'd0, 32'h402081B3, 1'b0);
        v[2]  = mk(OP_ALUI,  F_SRA,  5'd1,  5'd1,  5'd0,  32'd63,        3'd0, 32'h43F0D093, 1'b0);
        v[3]  = mk(OP_BNZ,   F_EQL,  5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,  3'd0, 32'hFE209EE3, 1'b0);
        v[4]  = mk(OP_LUI,   F_CPYB, 5'd5,  5'd0,  5'd0,  32'h12345000,  3'd0, 32'h123452B7, 1'b0);
        v[5]  = mk(OP_SD,    F_ADD,  5'd0,  5'd2,  5'd5,  32'd8,         3'd3, 32'h00513423, 1'b0);
        v[6]  = mk(OP_JAL,   F_ADD,  5'd1,  5'd0,  5'd0,  32'd2048,      3'd0, 32'h001000EF, 1'b0);
        v[7]  = mk(OP_ALUW,  F_DIVU, 5'd10, 5'd11, 5'd12, 32'd0,         3'd0, 32'h02C5D53B, 1'b0);
        v[8]  = mk(OP_LD,    F_ADD,  5'd6,  5'd7,  5'd0,  32'hFFFFF800,  3'd3, 32'h8003B303, 1'b0);
        v[9]  = mk(OP_BZ,    F_EQL,  5'd0,  5'd0,  5'd0,  32'd4094,      3'd0, 32'h7E000FE3, 1'b0);
        v[10] = mk(OP_ALUIW, F_SRA,  5'd2,  5'd3,  5'd0,  32'd31,        3'd0, 32'h41F1D11B, 1'b0);
        for (int i = 0; i < 11; i++) begin
            send_one(v[i], instr, err, lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL enc%0d_latency got %0d exp 1", i, lat); end
            checks++; if (instr !== v[i].exp_i) begin errors++; $display("FAIL enc%0d_instr got %h exp %h", i, instr, v[i].exp_i); end
            checks++; if (err !== v[i].exp_e) begin errors++; $display("FAIL enc%0d_err got %b exp %b", i, err, v[i].exp_e); end
        end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL enc_err_count got %0d exp 0", err_count); end
    endtask

    task automatic test_illegal;
        vec_t v[8];
        logic [31:0] instr; logic err; int lat;
        v[0] = mk(OP_ALUIW, F_SLL,    5'd1, 5'd1, 5'd0, 32'd32,       3'd0, 32'h00000013, 1'b1);
        v[1] = mk(OP_BZ,    F_EQL,    5'd0, 5'd1, 5'd2, 32'd3,        3'd0, 32'h00000013, 1'b1);
        v[2] = mk(OP_LUI,   F_CPYB,   5'd5, 5'd0, 5'd0, 32'h12345001, 3'd0, 32'h00000013, 1'b1);
        v[3] = mk(OP_SD,    F_ADD,    5'd0, 5'd2, 5'd5, 32'd8,        3'd4, 32'h00000013, 1'b1);
        v[4] = mk(OP_ALUI,  F_SUB,    5'd1, 5'd1, 5'd0, 32'd1,        3'd0, 32'h00000013, 1'b1);
        v[5] = mk(OP_JALR,  F_ADD,    5'd1, 5'd2, 5'd0, 32'd2048,     3'd0, 32'h00000013, 1'b1);
        v[6] = mk(OP_ALU,   F_NOTALU, 5'd1, 5'd2, 5'd3, 32'd0,        3'd0, 32'h00000013, 1'b1);
        v[7] = mk(OP_BZ,    F_EQL,    5'd0, 5'd1, 5'd2, 32'd4096,     3'd0, 32'h00000013, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_one(v[i], instr, err, lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL ill%0d_latency got %0d exp 1", i, lat); end
            checks++; if (instr !== v[i].exp_i) begin errors++; $display("FAIL ill%0d_instr got %h exp %h", i, instr, v[i].exp_i); end
            checks++; if (err !== v[i].exp_e) begin errors++; $display("FAIL ill%0d_err got %b exp %b", i, err, v[i].exp_e); end
            if (i == 0) begin
                checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL ill_first_err_count got %0d exp 1", err_count); end
            end
        end
        checks++; if (err_count !== 16'd8) begin errors++; $display("FAIL ill_err_count got %0d exp 8", err_count); end
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        logic [31:0] exp_i;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_req(mk(OP_ALUI, F_ADD, 5'(acc + 1), 5'd0, 5'd0, 32'(acc + 1), 3'd0, 32'h0, 1'b0));
            in_valid = 1'b1;
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (acc !== 5) begin errors++; $display("FAIL b2b_accepted got %0d exp 5", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full got %b exp 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_i = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
            checks++; if (out_valid !== 1'b1 || out_instr !== exp_i) begin
                errors++; $display("FAIL b2b_word%0d got v=%b %h exp v=1 %h", i, out_valid, out_instr, exp_i);
            end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        vec_t v[3];
        v[0] = mk(OP_ALUI, F_ADD, 5'd7, 5'd0, 5'd0, 32'd7, 3'd0, 32'h0, 1'b0);
        v[1] = mk(OP_ALUI, F_ADD, 5'd8, 5'd0, 5'd0, 32'd8, 3'd0, 32'h0, 1'b0);
        v[2] = mk(OP_ALUI, F_SUB, 5'd9, 5'd0, 5'd0, 32'd9, 3'd0, 32'h0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(v[i]); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b exp 1", out_valid); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        checks++; if (err_count !== 16'd8) begin errors++; $display("FAIL flush_err_count got %0d exp 8", err_count); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        vec_t v[3];
        v[0] = mk(OP_ALUIW, F_SLL, 5'd1, 5'd1, 5'd0, 32'd40, 3'd0, 32'h0, 1'b0);
        v[1] = mk(OP_ALUI,  F_ADD, 5'd2, 5'd0, 5'd0, 32'd2,  3'd0, 32'h0, 1'b0);
        v[2] = mk(OP_ALUI,  F_ADD, 5'd3, 5'd0, 5'd0, 32'd3,  3'd0, 32'h0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(v[i]); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (err_count !== 16'd9) begin errors++; $display("FAIL rst_pre_err_count got %0d exp 9", err_count); end
        resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_instr !== 32'h0 || out_err !== 1'b0) begin
            errors++; $display("FAIL rst_out_word got %h/%b exp 00000000/0", out_instr, out_err);
        end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_partial got %b exp 0", out_valid); end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_req(mk(OP_ALUI, F_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 3'd0, 32'h0, 1'b0));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_encode();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
